// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency memory between the
// fetch (IF) and data (MEM) pipeline stages. Each access is sequenced as
// grant -> one-cycle memEn -> fixed-latency wait -> one-cycle done pulse.
// Build macro ARB_PERF_CNT_EN adds saturating grant/conflict counters; when it
// is undefined the perf ports read zero and no counter logic exists.
module mem_port_arbiter #(
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        resetn,
   // fetch port
   input  logic        ifReq,
   input  logic [31:0] ifAddr,
   output logic [31:0] ifRdata,
   output logic        ifDone,
   // data port
   input  logic        dReq,
   input  logic        dWrite,
   input  logic [31:0] dAddr,
   input  logic [31:0] dWdata,
   input  logic [3:0]  dByteEn,
   output logic [31:0] dRdata,
   output logic        dDone,
   // memory port
   output logic        memEn,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [31:0] memWdata,
   output logic [3:0]  memBe,
   input  logic [31:0] memRdata,
   // pipeline control
   output logic        stallIF,
   output logic        stallMEM,
   output logic        busy,
   // performance counters
   output logic [31:0] perfIfGrants,
   output logic [31:0] perfDGrants,
   output logic [31:0] perfConflicts
);

   // Latency counter only has to hold MEM_LATENCY-1; starve counter holds 0..STARVE_LIMIT.
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [STV_W-1:0]  starve_q, starve_d;

   logic              grant_if;
   logic              grant_d;
   logic              lat_zero;

   // Data (the older instruction) wins a conflict unless fetch has been starved
   // for STARVE_LIMIT consecutive data grants. Only meaningful in IDLE.
   assign grant_if = ifReq & (~dReq | (starve_q == STV_MAX));
   assign grant_d  = dReq & ~grant_if;
   assign lat_zero = (lat_cnt_q == '0);

   // State and datapath registers; reset also discards any in-flight access.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_NONE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_be_q    <= 4'h0;
         if_rdata_q  <= 32'h0;
         d_rdata_q   <= 32'h0;
         lat_cnt_q   <= '0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         lat_cnt_q   <= lat_cnt_d;
         starve_q    <= starve_d;
      end
   end

   // Next-state sequencing: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (ifReq | dReq) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (lat_zero) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: latch the winner's command on the IDLE decision,
   // count down the latency in WAIT, and capture read data on its last cycle.
   always_comb begin
      owner_d     = owner_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      lat_cnt_d   = lat_cnt_q;
      starve_d    = starve_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_if) begin
               owner_d     = OWN_IF;
               mem_we_d    = 1'b0;
               mem_addr_d  = ifAddr;
               mem_wdata_d = 32'h0;
               mem_be_d    = 4'hF;
               starve_d    = '0;
            end else if (grant_d) begin
               owner_d     = OWN_D;
               mem_we_d    = dWrite;
               mem_addr_d  = dAddr;
               mem_wdata_d = dWdata;
               mem_be_d    = dByteEn;
               // Only a grant that bypasses a waiting fetch counts as starvation.
               if (ifReq && (starve_q != STV_MAX)) starve_d = starve_q + STV_W'(1);
            end
         end
         S_ISSUE: begin
            lat_cnt_d = LAT_LOAD;
         end
         S_WAIT: begin
            if (lat_zero) begin
               // memRdata is valid in this cycle; stores leave dRdata untouched.
               if (owner_q == OWN_IF) begin
                  if_rdata_d = memRdata;
               end else if ((owner_q == OWN_D) && !mem_we_q) begin
                  d_rdata_d = memRdata;
               end
            end else begin
               lat_cnt_d = lat_cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            owner_d = OWN_NONE;
         end
         default: ;
      endcase
   end

   // Outputs decoded from the current state and owner.
   always_comb begin
      memEn  = (state_q == S_ISSUE);
      ifDone = (state_q == S_DONE) && (owner_q == OWN_IF);
      dDone  = (state_q == S_DONE) && (owner_q == OWN_D);
      busy   = (state_q != S_IDLE);
   end

   assign memWe    = mem_we_q;
   assign memAddr  = mem_addr_q;
   assign memWdata = mem_wdata_q;
   assign memBe    = mem_be_q;
   assign ifRdata  = if_rdata_q;
   assign dRdata   = d_rdata_q;

   // Stalls release combinationally in the Done cycle.
   assign stallIF  = ifReq & ~ifDone;
   assign stallMEM = dReq & ~dDone;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_if_q, perf_if_d;
   logic [31:0] perf_d_q, perf_d_d;
   logic [31:0] perf_cf_q, perf_cf_d;

   // Saturating counts of grants and of IDLE cycles where both stages request.
   always_comb begin
      perf_if_d = perf_if_q;
      perf_d_d  = perf_d_q;
      perf_cf_d = perf_cf_q;
      if (state_q == S_IDLE) begin
         if (grant_if && (perf_if_q != 32'hFFFF_FFFF)) perf_if_d = perf_if_q + 32'd1;
         if (grant_d && (perf_d_q != 32'hFFFF_FFFF))   perf_d_d  = perf_d_q + 32'd1;
         if (ifReq && dReq && (perf_cf_q != 32'hFFFF_FFFF)) perf_cf_d = perf_cf_q + 32'd1;
      end
   end

   // Performance counter registers, cleared by reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         perf_if_q <= 32'h0;
         perf_d_q  <= 32'h0;
         perf_cf_q <= 32'h0;
      end else begin
         perf_if_q <= perf_if_d;
         perf_d_q  <= perf_d_d;
         perf_cf_q <= perf_cf_d;
      end
   end

   assign perfIfGrants  = perf_if_q;
   assign perfDGrants   = perf_d_q;
   assign perfConflicts = perf_cf_q;
`else
   assign perfIfGrants  = 32'h0;
   assign perfDGrants   = 32'h0;
   assign perfConflicts = 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (MEM_LATENCY=2,
// STARVE_LIMIT=4). Expected memory commands and done responses are queued as
// requests are driven and compared when the DUT produces them.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        clock;
   logic        resetn;
   logic        ifReq;
   logic [31:0] ifAddr;
   logic [31:0] ifRdata;
   logic        ifDone;
   logic        dReq;
   logic        dWrite;
   logic [31:0] dAddr;
   logic [31:0] dWdata;
   logic [3:0]  dByteEn;
   logic [31:0] dRdata;
   logic        dDone;
   logic        memEn;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [3:0]  memBe;
   logic [31:0] memRdata;
   logic        stallIF;
   logic        stallMEM;
   logic        busy;
   logic [31:0] perfIfGrants;
   logic [31:0] perfDGrants;
   logic [31:0] perfConflicts;

   mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
      .clock(clock), .resetn(resetn),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifDone(ifDone),
      .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWdata(dWdata),
      .dByteEn(dByteEn), .dRdata(dRdata), .dDone(dDone),
      .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memBe(memBe), .memRdata(memRdata),
      .stallIF(stallIF), .stallMEM(stallMEM), .busy(busy),
      .perfIfGrants(perfIfGrants), .perfDGrants(perfDGrants),
      .perfConflicts(perfConflicts)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          cyc;
   } cmd_t;

   typedef struct {
      logic [31:0] rdata;
      int          cyc;
   } rsp_exp_t;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } mem_rsp_t;

   cmd_t     cmd_q[$];
   rsp_exp_t if_q[$];
   rsp_exp_t d_q[$];
   mem_rsp_t mem_q[$];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          exp_if_g = 0;
   int          exp_d_g  = 0;
   int          exp_conf = 0;
   logic [31:0] last_load = 32'h0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0040_0000) ? 32'h0000_0013 : (a ^ 32'h5A5A_F00D);
   endfunction

   task automatic push_cmd(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input int c);
      cmd_t e;
      e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.cyc = c;
      cmd_q.push_back(e);
   endtask

   task automatic push_if(input logic [31:0] rd, input int c);
      rsp_exp_t e;
      e.rdata = rd; e.cyc = c;
      if_q.push_back(e);
   endtask

   task automatic push_d(input logic [31:0] rd, input int c);
      rsp_exp_t e;
      e.rdata = rd; e.cyc = c;
      d_q.push_back(e);
   endtask

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   // Memory model: read data valid only in the cycle exactly LAT after memEn.
   initial begin
      memRdata = 32'h0;
      forever begin
         @(posedge clock);
         #1;
         while (mem_q.size() > 0 && mem_q[0].due < cyc) void'(mem_q.pop_front());
         if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            memRdata = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
         end else begin
            memRdata = 32'hBAD0_0000 | 32'(cyc[15:0]);
         end
      end
   end

   // Monitor: compares every memory strobe and done pulse with the scoreboard.
   initial begin
      forever begin
         @(negedge clock);
         if (memEn) begin
            mem_rsp_t r;
            r.due = cyc + LAT; r.addr = memAddr;
            mem_q.push_back(r);
            if (cmd_q.size() == 0) begin
               check_val("mem_en_unexpected", 1, 0);
            end else begin
               cmd_t c;
               c = cmd_q.pop_front();
               check_val("mem_en_cycle", cyc, c.cyc);
               check_val("mem_addr", memAddr, c.addr);
               check_val("mem_we", memWe, c.we);
               check_val("mem_be", memBe, c.be);
               if (c.we) check_val("mem_wdata", memWdata, c.wdata);
            end
         end
         if (ifDone && dDone) check_val("both_done", 1, 0);
         if (ifDone) begin
            if (if_q.size() == 0) begin
               check_val("if_done_unexpected", 1, 0);
            end else begin
               rsp_exp_t e;
               e = if_q.pop_front();
               check_val("if_done_cycle", cyc, e.cyc);
               check_val("if_rdata", ifRdata, e.rdata);
            end
         end
         if (dDone) begin
            if (d_q.size() == 0) begin
               check_val("d_done_unexpected", 1, 0);
            end else begin
               rsp_exp_t e;
               e = d_q.pop_front();
               check_val("d_done_cycle", cyc, e.cyc);
               check_val("d_rdata", dRdata, e.rdata);
            end
         end
      end
   end

   // Fetch requester: holds ifReq until ifDone, then drops it.
   task automatic run_fetch(input logic [31:0] a);
      bit seen = 1'b0;
      ifReq = 1'b1; ifAddr = a;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clock);
         if (i == 0) check_val("stall_if_pending", stallIF, 1);
         if (ifDone) begin
            seen = 1'b1;
            check_val("stall_if_done", stallIF, 0);
         end
      end
      check_val("if_done_seen", seen, 1);
      ifReq = 1'b0;
   endtask

   // Data requester: holds dReq with a stable command until dDone.
   task automatic run_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
      bit seen = 1'b0;
      dReq = 1'b1; dWrite = we; dAddr = a; dWdata = wd; dByteEn = be;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clock);
         if (i == 0) check_val("stall_mem_pending", stallMEM, 1);
         if (dDone) begin
            seen = 1'b1;
            check_val("stall_mem_done", stallMEM, 0);
         end
      end
      check_val("d_done_seen", seen, 1);
      dReq = 1'b0;
   endtask

   task automatic check_perf(input string tag);
`ifdef ARB_PERF_CNT_EN
      check_val({tag, "_perf_if"}, perfIfGrants, exp_if_g);
      check_val({tag, "_perf_d"}, perfDGrants, exp_d_g);
      check_val({tag, "_perf_conf"}, perfConflicts, exp_conf);
`else
      check_val({tag, "_perf_if"}, perfIfGrants, 0);
      check_val({tag, "_perf_d"}, perfDGrants, 0);
      check_val({tag, "_perf_conf"}, perfConflicts, 0);
`endif
   endtask

   // Both stages request in the same IDLE cycle; data is expected to win.
   task automatic run_conflict(input logic [31:0] fa, input logic [31:0] da);
      int t0;
      t0 = cyc;
      push_cmd(da, 1'b0, 4'hF, 32'h0, t0 + 1);
      push_cmd(fa, 1'b0, 4'hF, 32'h0, t0 + 6);
      push_d(mem_word(da), t0 + 4);
      push_if(mem_word(fa), t0 + 9);
      last_load = mem_word(da);
      exp_d_g++; exp_if_g++; exp_conf++;
      fork
         run_fetch(fa);
         run_data(1'b0, da, 32'h0, 4'hF);
      join
      @(negedge clock);
   endtask

   initial begin
      int t0;
      resetn = 1'b0; ifReq = 1'b0; ifAddr = 32'h0;
      dReq = 1'b0; dWrite = 1'b0; dAddr = 32'h0; dWdata = 32'h0; dByteEn = 4'h0;

      repeat (3) @(negedge clock);
      check_val("rst_busy", busy, 0);
      check_val("rst_mem_en", memEn, 0);
      check_val("rst_mem_addr", memAddr, 0);
      check_val("rst_mem_be", memBe, 0);
      check_val("rst_if_rdata", ifRdata, 0);
      check_val("rst_d_rdata", dRdata, 0);
      check_val("rst_done", {ifDone, dDone}, 0);
      check_perf("rst");
      resetn = 1'b1;
      @(negedge clock);

      // Fetch only
      t0 = cyc;
      push_cmd(32'h0040_0000, 1'b0, 4'hF, 32'h0, t0 + 1);
      push_if(32'h0000_0013, t0 + 4);
      exp_if_g++;
      run_fetch(32'h0040_0000);
      @(negedge clock);

      // Load, so the following store can show dRdata is kept
      t0 = cyc;
      push_cmd(32'h1001_0000, 1'b0, 4'hF, 32'h0, t0 + 1);
      push_d(mem_word(32'h1001_0000), t0 + 4);
      last_load = mem_word(32'h1001_0000);
      exp_d_g++;
      run_data(1'b0, 32'h1001_0000, 32'h0, 4'hF);
      @(negedge clock);

      // Store
      t0 = cyc;
      push_cmd(32'h1001_0004, 1'b1, 4'b0011, 32'hDEAD_BEEF, t0 + 1);
      push_d(last_load, t0 + 4);
      exp_d_g++;
      run_data(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b0011);
      @(negedge clock);

      // Conflict
      run_conflict(32'h0040_0004, 32'h1001_0008);
      check_perf("conflict");

      // Starvation: fetch held while data re-requests back to back
      t0 = cyc;
      for (int k = 0; k < 4; k++) begin
         push_cmd(32'h1001_0100 + 32'(4 * k), 1'b0, 4'hF, 32'h0, t0 + 1 + 5 * k);
         push_d(mem_word(32'h1001_0100 + 32'(4 * k)), t0 + 4 + 5 * k);
      end
      push_cmd(32'h0040_0008, 1'b0, 4'hF, 32'h0, t0 + 21);
      push_if(mem_word(32'h0040_0008), t0 + 24);
      push_cmd(32'h1001_0110, 1'b0, 4'hF, 32'h0, t0 + 26);
      push_d(mem_word(32'h1001_0110), t0 + 29);
      last_load = mem_word(32'h1001_0110);
      exp_d_g += 5; exp_if_g++; exp_conf += 5;
      fork
         run_fetch(32'h0040_0008);
         begin
            for (int k = 0; k < 5; k++) run_data(1'b0, 32'h1001_0100 + 32'(4 * k), 32'h0, 4'hF);
         end
      join
      @(negedge clock);

      // Starve counter must have cleared: data wins the next conflict again
      run_conflict(32'h0040_000C, 32'h1001_0200);
      check_perf("starve");

      // Reset during WAIT: access abandoned, no done pulse
      t0 = cyc;
      push_cmd(32'h1001_0300, 1'b0, 4'hF, 32'h0, t0 + 1);
      dReq = 1'b1; dWrite = 1'b0; dAddr = 32'h1001_0300; dByteEn = 4'hF;
      @(negedge clock);
      @(negedge clock);
      check_val("wait_busy", busy, 1);
      resetn = 1'b0; dReq = 1'b0;
      @(negedge clock);
      check_val("rst_mid_busy", busy, 0);
      check_val("rst_mid_mem_en", memEn, 0);
      check_val("rst_mid_done", {ifDone, dDone}, 0);
      check_val("rst_mid_d_rdata", dRdata, 0);
      resetn = 1'b1;
      exp_if_g = 0; exp_d_g = 0; exp_conf = 0; last_load = 32'h0;
      repeat (4) @(negedge clock);
      check_val("post_rst_busy", busy, 0);
      check_perf("post_rst");

      // Fresh request after reset completes normally
      t0 = cyc;
      push_cmd(32'h0040_0010, 1'b0, 4'hF, 32'h0, t0 + 1);
      push_if(mem_word(32'h0040_0010), t0 + 4);
      exp_if_g++;
      run_fetch(32'h0040_0010);
      repeat (2) @(negedge clock);
      check_perf("final");

      check_val("cmd_left", cmd_q.size(), 0);
      check_val("if_left", if_q.size(), 0);
      check_val("d_left", d_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
